// File: rtl/tst_strobe_gen.sv
// Frame strobe sequencer: emits TNC/TNO/TNI/TKI/TNP/TKP and the TOBM window
// from a double-buffered schedule, advancing one position per tick.
module tst_strobe_gen #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             en,
    input  logic             cfg_wr,
    input  logic [2:0]       cfg_addr,
    input  logic [CNT_W-1:0] cfg_data,
    output logic             TNC,
    output logic             TNO,
    output logic             TNI,
    output logic             TKI,
    output logic             TNP,
    output logic             TKP,
    output logic             TOBM,
    output logic             busy,
    output logic [15:0]      frame_cnt
);

    // state  | meaning
    // S_IDLE | stopped, pos held at 0, outputs quiet
    // S_RUN  | framing; pos advances on every tick
    typedef enum logic {S_IDLE, S_RUN} state_t;

    localparam logic [CNT_W-1:0] RST_PER = CNT_W'(1000);
    localparam logic [CNT_W-1:0] RST_NI  = CNT_W'(10);
    localparam logic [CNT_W-1:0] RST_KI  = CNT_W'(110);
    localparam logic [CNT_W-1:0] RST_NP  = CNT_W'(200);
    localparam logic [CNT_W-1:0] RST_KP  = CNT_W'(900);
    localparam logic [CNT_W-1:0] RST_GRP = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] pos_q, pos_d;
    logic [CNT_W-1:0] grp_q, grp_d;

    logic [CNT_W-1:0] sh_per_q, sh_per_d, sh_ni_q, sh_ni_d, sh_ki_q, sh_ki_d;
    logic [CNT_W-1:0] sh_np_q, sh_np_d, sh_kp_q, sh_kp_d, sh_grp_q, sh_grp_d;

    logic [CNT_W-1:0] act_per_q, act_per_d, act_ni_q, act_ni_d, act_ki_q, act_ki_d;
    logic [CNT_W-1:0] act_np_q, act_np_d, act_kp_q, act_kp_d, act_grp_q, act_grp_d;

    logic tnc_q, tnc_d, tno_q, tno_d, tni_q, tni_d, tki_q, tki_d;
    logic tnp_q, tnp_d, tkp_q, tkp_d, tobm_q, tobm_d;
    logic [15:0] fc_q, fc_d;

    logic             load;
    logic             evt;
    logic [CNT_W-1:0] grp_inc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pos_q     <= '0;
            grp_q     <= '0;
            sh_per_q  <= RST_PER;
            sh_ni_q   <= RST_NI;
            sh_ki_q   <= RST_KI;
            sh_np_q   <= RST_NP;
            sh_kp_q   <= RST_KP;
            sh_grp_q  <= RST_GRP;
            act_per_q <= RST_PER;
            act_ni_q  <= RST_NI;
            act_ki_q  <= RST_KI;
            act_np_q  <= RST_NP;
            act_kp_q  <= RST_KP;
            act_grp_q <= RST_GRP;
            tnc_q     <= 1'b0;
            tno_q     <= 1'b0;
            tni_q     <= 1'b0;
            tki_q     <= 1'b0;
            tnp_q     <= 1'b0;
            tkp_q     <= 1'b0;
            tobm_q    <= 1'b0;
            fc_q      <= '0;
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            grp_q     <= grp_d;
            sh_per_q  <= sh_per_d;
            sh_ni_q   <= sh_ni_d;
            sh_ki_q   <= sh_ki_d;
            sh_np_q   <= sh_np_d;
            sh_kp_q   <= sh_kp_d;
            sh_grp_q  <= sh_grp_d;
            act_per_q <= act_per_d;
            act_ni_q  <= act_ni_d;
            act_ki_q  <= act_ki_d;
            act_np_q  <= act_np_d;
            act_kp_q  <= act_kp_d;
            act_grp_q <= act_grp_d;
            tnc_q     <= tnc_d;
            tno_q     <= tno_d;
            tni_q     <= tni_d;
            tki_q     <= tki_d;
            tnp_q     <= tnp_d;
            tkp_q     <= tkp_d;
            tobm_q    <= tobm_d;
            fc_q      <= fc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        grp_d     = grp_q;
        sh_per_d  = sh_per_q;
        sh_ni_d   = sh_ni_q;
        sh_ki_d   = sh_ki_q;
        sh_np_d   = sh_np_q;
        sh_kp_d   = sh_kp_q;
        sh_grp_d  = sh_grp_q;
        act_per_d = act_per_q;
        act_ni_d  = act_ni_q;
        act_ki_d  = act_ki_q;
        act_np_d  = act_np_q;
        act_kp_d  = act_kp_q;
        act_grp_d = act_grp_q;
        tnc_d     = 1'b0;
        tno_d     = 1'b0;
        tni_d     = 1'b0;
        tki_d     = 1'b0;
        tnp_d     = 1'b0;
        tkp_d     = 1'b0;
        tobm_d    = tobm_q;
        fc_d      = fc_q;
        load      = 1'b0;
        evt       = 1'b0;
        grp_inc   = grp_q + CNT_W'(1);

        if (cfg_wr) begin
            case (cfg_addr)
                3'd0:    sh_per_d = cfg_data;
                3'd1:    sh_ni_d  = cfg_data;
                3'd2:    sh_ki_d  = cfg_data;
                3'd3:    sh_np_d  = cfg_data;
                3'd4:    sh_kp_d  = cfg_data;
                3'd5:    sh_grp_d = cfg_data;
                default: ;
            endcase
        end

        if (tick) begin
            case (state_q)
                S_IDLE: begin
                    if (en) begin
                        state_d = S_RUN;
                        load    = 1'b1;
                        pos_d   = '0;
                        grp_d   = '0;
                        tnc_d   = 1'b1;
                        tno_d   = 1'b1;
                        evt     = 1'b1;
                    end
                end
                S_RUN: begin
                    if (pos_q == act_per_q - CNT_W'(1)) begin
                        pos_d = '0;
                        if (!en) begin
                            state_d = S_IDLE;
                        end else begin
                            load  = 1'b1;
                            tnc_d = 1'b1;
                            evt   = 1'b1;
                        end
                    end else begin
                        pos_d = pos_q + CNT_W'(1);
                        evt   = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Loads read the shadow _q values, so a same-clk write waits a frame.
        if (load) begin
            act_per_d = (sh_per_q < CNT_W'(2)) ? CNT_W'(2) : sh_per_q;
            act_ni_d  = sh_ni_q;
            act_ki_d  = sh_ki_q;
            act_np_d  = sh_np_q;
            act_kp_d  = sh_kp_q;
            act_grp_d = (sh_grp_q == '0) ? CNT_W'(1) : sh_grp_q;
        end

        // Group wraps against the freshly loaded size so grp never overshoots it.
        if (load && state_q == S_RUN) begin
            grp_d = (grp_inc >= act_grp_d) ? '0 : grp_inc;
            tno_d = (grp_d == '0);
        end

        if (evt) begin
            tni_d = (pos_d == act_ni_d);
            tki_d = (pos_d == act_ki_d);
            tnp_d = (pos_d == act_np_d);
            tkp_d = (pos_d == act_kp_d);
            if (tki_d)
                tobm_d = 1'b0;
            else if (tni_d)
                tobm_d = 1'b1;
        end

        if (tnc_d)
            fc_d = fc_q + 16'd1;

        if (state_d == S_IDLE)
            tobm_d = 1'b0;
    end

    assign TNC       = tnc_q;
    assign TNO       = tno_q;
    assign TNI       = tni_q;
    assign TKI       = tki_q;
    assign TNP       = tnp_q;
    assign TKP       = tkp_q;
    assign TOBM      = tobm_q;
    assign busy      = (state_q == S_RUN);
    assign frame_cnt = fc_q;

endmodule

// File: tb/tb_tst_strobe_gen.sv
// Scoreboard bench for tst_strobe_gen: a tick-level frame model pushes the
// expected output vector each clk; a monitor pops and compares on the falling edge.
module tb_tst_strobe_gen;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        tick = 1'b0;
   logic        en = 1'b0;
   logic        cfg_wr = 1'b0;
   logic [2:0]  cfg_addr = '0;
   logic [15:0] cfg_data = '0;
   logic        TNC, TNO, TNI, TKI, TNP, TKP, TOBM, busy;
   logic [15:0] frame_cnt;

   int n_cmp = 0;
   int n_err = 0;
   logic [23:0] exp_q[$];

   tst_strobe_gen #(.CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .tick(tick), .en(en),
      .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .TNC(TNC), .TNO(TNO), .TNI(TNI), .TKI(TKI), .TNP(TNP), .TKP(TKP),
      .TOBM(TOBM), .busy(busy), .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   // Reference model: schedule as integers, one frame position per tick.
   int sh[6];
   int a_sched[6];
   bit m_run = 0;
   int m_pos = 0, m_grp = 0, m_frames = 0;
   bit m_tobm = 0;

   function automatic void m_reset();
      sh[0] = 1000; sh[1] = 10; sh[2] = 110; sh[3] = 200; sh[4] = 900; sh[5] = 1;
      for (int i = 0; i < 6; i++) a_sched[i] = sh[i];
      m_run = 0; m_pos = 0; m_grp = 0; m_frames = 0; m_tobm = 0;
   endfunction

   function automatic void m_load();
      for (int i = 0; i < 6; i++) a_sched[i] = sh[i];
      if (a_sched[0] < 2) a_sched[0] = 2;
      if (a_sched[5] < 1) a_sched[5] = 1;
   endfunction

   always @(posedge clk) begin
      bit s_nc, s_no, s_ni, s_ki, s_np, s_kp, s_frame;
      s_nc = 0; s_no = 0; s_ni = 0; s_ki = 0; s_np = 0; s_kp = 0; s_frame = 0;
      if (!rst_n) begin
         m_reset();
      end else begin
         if (tick) begin
            if (!m_run) begin
               if (en) begin
                  m_load();
                  m_run = 1; m_pos = 0; m_grp = 0;
                  s_nc = 1; s_no = 1; s_frame = 1;
               end
            end else if (m_pos == a_sched[0] - 1) begin
               m_pos = 0;
               if (!en) begin
                  m_run = 0;
               end else begin
                  m_load();
                  m_grp = (m_grp + 1 < a_sched[5]) ? m_grp + 1 : 0;
                  s_nc = 1; s_no = (m_grp == 0); s_frame = 1;
               end
            end else begin
               m_pos++;
               s_frame = 1;
            end
            if (s_frame) begin
               s_ni = (m_pos == a_sched[1]);
               s_ki = (m_pos == a_sched[2]);
               s_np = (m_pos == a_sched[3]);
               s_kp = (m_pos == a_sched[4]);
               if (s_ki) m_tobm = 0;
               else if (s_ni) m_tobm = 1;
            end
            if (s_nc) m_frames = (m_frames + 1) % 65536;
         end
         if (!m_run) m_tobm = 0;
         if (cfg_wr && cfg_addr < 3'd6) sh[cfg_addr] = int'(cfg_data);
      end
      exp_q.push_back({s_nc, s_no, s_ni, s_ki, s_np, s_kp, m_tobm, m_run, 16'(m_frames)});
   end

   always @(negedge clk) begin
      logic [23:0] act, want;
      if (exp_q.size() > 0) begin
         want = exp_q.pop_front();
         act = {TNC, TNO, TNI, TKI, TNP, TKP, TOBM, busy, frame_cnt};
         n_cmp++;
         if (act !== want) begin
            n_err++;
            $display("FAIL outputs @%0t: got TNC/TNO/TNI/TKI/TNP/TKP/TOBM/busy=%b frame_cnt=%0d, want %b frame_cnt=%0d",
                     $time, act[23:16], act[15:0], want[23:16], want[15:0]);
         end
      end
   end

   initial begin
      #4000000;
      n_err++;
      $display("FAIL timeout @%0t: stimulus did not complete within the wait limit", $time);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $display("*** TEST FAILED ***");
      $finish;
   end

   task automatic check_idle(string tag);
      logic [23:0] act;
      act = {TNC, TNO, TNI, TKI, TNP, TKP, TOBM, busy, frame_cnt};
      n_cmp++;
      if (act !== 24'd0) begin
         n_err++;
         $display("FAIL reset state (%s) @%0t: got strobes/TOBM/busy=%b frame_cnt=%0d, want all 0",
                  tag, $time, act[23:16], act[15:0]);
      end
   endtask

   task automatic tick_n(int n, int gap);
      for (int i = 0; i < n; i++) begin
         for (int g = 1; g < gap; g++) begin
            tick = 1'b0;
            @(negedge clk);
         end
         tick = 1'b1;
         @(negedge clk);
      end
      tick = 1'b0;
   endtask

   task automatic wr(int addr, int data);
      cfg_wr = 1'b1; cfg_addr = 3'(addr); cfg_data = 16'(data);
      @(negedge clk);
      cfg_wr = 1'b0;
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      @(negedge clk);
      check_idle("pulse");
      rst_n = 1'b1;
   endtask

   task automatic stop(int max_period);
      en = 1'b0;
      tick_n(max_period + 2, 1);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_idle("power-up");
      rst_n = 1'b1;
      @(negedge clk);

      // Default schedule, tick every 4 clk, two full frames.
      en = 1'b1;
      tick_n(1, 4);
      tick_n(2001, 4);
      stop(1000);

      // Groups of 3 with TNI on every TNC, 7 frames.
      wr(0, 20); wr(5, 3); wr(1, 0);
      en = 1'b1;
      tick_n(1 + 20 * 6 + 5, 2);
      stop(20);

      // Mid-frame T_NP write only takes effect at the next frame.
      en = 1'b1;
      tick_n(9, 1);
      wr(3, 5);
      tick_n(50, 1);
      stop(20);

      // Coincident TNI/TKI, out-of-range TKP, degenerate period.
      wr(1, 7); wr(2, 7); wr(4, 25);
      en = 1'b1;
      tick_n(45, 1);
      wr(0, 0);
      tick_n(30, 3);
      stop(20);

      // en dropped mid-frame: frame completes, no TNC at the wrap.
      wr(0, 10); wr(1, 5); wr(2, 8); wr(3, 6); wr(4, 9);
      en = 1'b1;
      tick_n(4, 1);
      en = 1'b0;
      tick_n(12, 2);
      repeat (4) @(negedge clk);

      // Reset mid-frame with TOBM high, then default schedule again.
      pulse_reset();
      en = 1'b1;
      tick_n(51, 1);
      pulse_reset();
      repeat (2) @(negedge clk);
      tick_n(1002, 1);
      stop(1000);

      // Randomized schedule, tick spacing, en and writes.
      wr(0, 12);
      for (int it = 0; it < 400; it++) begin
         case ($urandom_range(0, 9))
            0: wr(0, $urandom_range(0, 30));
            1: wr($urandom_range(1, 4), $urandom_range(0, 35));
            2: wr(5, $urandom_range(0, 4));
            3: wr($urandom_range(6, 7), $urandom);
            4: en = ~en;
            5: if ($urandom_range(0, 7) == 0) pulse_reset();
            default: begin
               cfg_wr = ($urandom_range(0, 3) == 0);
               cfg_addr = 3'($urandom_range(0, 7));
               cfg_data = 16'($urandom_range(0, 35));
               tick_n($urandom_range(1, 15), $urandom_range(1, 3));
               cfg_wr = 1'b0;
            end
         endcase
      end
      if (rst_n) stop(1000);
      repeat (3) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      if (n_err == 0 && n_cmp > 0)
         $display("*** TEST PASSED ***");
      else
         $display("*** TEST FAILED ***");
      $finish;
   end

endmodule
